// File: rtl/ps2_host_tx.sv
`timescale 1ns / 1ps
// ps2_host_tx
// -----------------------------------------------------------------------------
// Host-to-device PS/2 transmitter. It sends one command byte, for example
// 0xED (set LEDs) or 0xFF (reset), to an attached keyboard. The frame is a
// start bit, 8 data bits LSB first, an odd parity bit and a stop bit. The
// device acknowledge bit is then checked. This block sits beside the
// device-to-host receiver. Both PS/2 lines are open-drain, so the block only
// ever pulls them low through output enables.
//
// Ports
//   clock        system clock (100 MHz nominal)
//   reset        synchronous, active-high reset
//   tx_data      command byte, captured together with an accepted tx_start
//   tx_start     single-cycle request, honoured only while tx_ready = 1
//   tx_ready     1 = idle and able to accept tx_start
//   tx_busy      1 = transaction in progress (always the complement of tx_ready)
//   tx_done      1-cycle pulse: byte sent and acknowledged by the device
//   tx_error     1-cycle pulse: transaction failed
//   err_code     01 = timeout, 10 = no acknowledge. Valid with tx_error and
//                held until the next accepted tx_start
//   ps2_clk_in   asynchronous pad level of the PS/2 clock
//   ps2_data_in  asynchronous pad level of the PS/2 data
//   ps2_clk_oe   1 = pull the PS/2 clock low
//   ps2_data_oe  1 = pull the PS/2 data low
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES    = 12000,
    parameter int START_HOLD_CYCLES = 200,
    parameter int FILTER_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES    = 1500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // ------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------
    // One phase counter serves both INHIBIT and START, so it is sized for
    // the longer of the two.
    localparam int PHASE_MAX = (INHIBIT_CYCLES > START_HOLD_CYCLES) ?
                               INHIBIT_CYCLES : START_HOLD_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FILT_W    = $clog2(FILTER_CYCLES + 1);

    localparam logic [PHASE_W-1:0] INHIBIT_LAST = PHASE_W'(INHIBIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] START_LAST   = PHASE_W'(START_HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FILT_W-1:0]  FILT_LAST    = FILT_W'(FILTER_CYCLES - 1);

    // Index of the stop bit in the 10-bit shift frame {stop, parity, data}.
    localparam logic [3:0] STOP_IDX = 4'd9;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronisers on both pad inputs.
    // Bit 0 carries the clock and bit 1 carries the data.
    // ------------------------------------------------------------------
    logic [1:0] pad_level;
    logic [1:0] pad_sync;

    assign pad_level = {ps2_data_in, ps2_clk_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_q;
            logic stage_q;

            // Reset to 1 because an idle PS/2 line is high. A reset therefore
            // never looks like a line transition.
            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_q  <= 1'b1;
                    stage_q <= 1'b1;
                end else begin
                    meta_q  <= pad_level[gi];
                    stage_q <= meta_q;
                end
            end

            assign pad_sync[gi] = stage_q;
        end
    endgenerate

    logic clk_sync;
    logic data_sync;

    assign clk_sync  = pad_sync[0];
    assign data_sync = pad_sync[1];

    // ------------------------------------------------------------------
    // Clock stability filter. The filtered level follows the synchronised
    // clock only after the new level has been seen for FILTER_CYCLES
    // consecutive clocks. fall_q is high for exactly one cycle: the first
    // cycle in which the filtered clock reads 0.
    // ------------------------------------------------------------------
    logic              filt_clk_q;
    logic [FILT_W-1:0] filt_cnt_q;
    logic              fall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_sync == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_clk_q <= clk_sync;
                filt_cnt_q <= '0;
                fall_q     <= ~clk_sync;
            end else begin
                filt_cnt_q <= filt_cnt_q + FILT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;
    logic [3:0]         bit_idx_q,   bit_idx_d;
    logic [9:0]         frame_q,     frame_d;
    logic [1:0]         err_code_q,  err_code_d;
    logic               tx_done_q,   tx_done_d;
    logic               tx_error_q,  tx_error_d;
    logic               tx_ready_q,  tx_ready_d;
    logic               clk_oe_q,    clk_oe_d;
    logic               data_oe_q,   data_oe_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_cnt_q <= '0;
            to_cnt_q    <= '0;
            bit_idx_q   <= '0;
            frame_q     <= '0;
            err_code_q  <= ERR_NONE;
            tx_done_q   <= 1'b0;
            tx_error_q  <= 1'b0;
            tx_ready_q  <= 1'b1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            to_cnt_q    <= to_cnt_d;
            bit_idx_q   <= bit_idx_d;
            frame_q     <= frame_d;
            err_code_q  <= err_code_d;
            tx_done_q   <= tx_done_d;
            tx_error_q  <= tx_error_d;
            tx_ready_q  <= tx_ready_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        to_cnt_d    = to_cnt_q;
        bit_idx_d   = bit_idx_q;
        frame_d     = frame_q;
        err_code_d  = err_code_q;
        tx_done_d   = 1'b0;
        tx_error_d  = 1'b0;
        data_oe_d   = data_oe_q;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_start && tx_ready_q) begin
                    // The frame is shifted out from bit 0: data LSB first,
                    // then odd parity, then stop.
                    frame_d     = {1'b1, ~^tx_data, tx_data};
                    err_code_d  = ERR_NONE;
                    phase_cnt_d = '0;
                    state_d     = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (phase_cnt_q == INHIBIT_LAST) begin
                    phase_cnt_d = '0;
                    data_oe_d   = 1'b1;
                    state_d     = S_START;
                end else begin
                    phase_cnt_d = phase_cnt_q + PHASE_W'(1);
                end
            end

            S_START: begin
                // Data held low here is the start bit. It stays driven after
                // the clock is released, until the first device fall.
                data_oe_d = 1'b1;
                if (phase_cnt_q == START_LAST) begin
                    phase_cnt_d = '0;
                    to_cnt_d    = '0;
                    bit_idx_d   = '0;
                    state_d     = S_SEND;
                end else begin
                    phase_cnt_d = phase_cnt_q + PHASE_W'(1);
                end
            end

            S_SEND: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (to_cnt_q == TO_LAST) begin
                    state_d    = S_IDLE;
                    tx_error_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    data_oe_d  = 1'b0;
                end else if (fall_q) begin
                    // Open-drain: a '1' bit is sent by releasing the line.
                    data_oe_d = ~frame_q[bit_idx_q];
                    if (bit_idx_q == STOP_IDX) begin
                        state_d = S_ACK;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end

            S_ACK: begin
                to_cnt_d  = to_cnt_q + TO_W'(1);
                data_oe_d = 1'b0;
                if (to_cnt_q == TO_LAST) begin
                    state_d    = S_IDLE;
                    tx_error_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else if (fall_q) begin
                    if (data_sync) begin
                        state_d    = S_IDLE;
                        tx_error_d = 1'b1;
                        err_code_d = ERR_NOACK;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                to_cnt_d  = to_cnt_q + TO_W'(1);
                data_oe_d = 1'b0;
                if (to_cnt_q == TO_LAST) begin
                    state_d    = S_IDLE;
                    tx_error_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else if (data_sync && filt_clk_q) begin
                    state_d   = S_IDLE;
                    tx_done_d = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                data_oe_d = 1'b0;
            end
        endcase

        // The registered outputs follow the next state. That way they change
        // on the same edge as the state, with no combinational decode at the
        // pads.
        clk_oe_d   = (state_d == S_INHIBIT) || (state_d == S_START);
        tx_ready_d = (state_d == S_IDLE);
    end

    assign tx_ready    = tx_ready_q;
    assign tx_busy     = ~tx_ready_q;
    assign tx_done     = tx_done_q;
    assign tx_error    = tx_error_q;
    assign err_code    = err_code_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns / 1ps
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int HOLD = 10;
    localparam int FILT = 2;
    localparam int TO   = 20000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         err_cyc = 0;
    logic [1:0] last_code = 2'b00;

    // Open-drain bus: the line is low if either side pulls it.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .START_HOLD_CYCLES (HOLD),
        .FILTER_CYCLES     (FILT),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .err_code    (err_code),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse bookkeeping
    always @(negedge clock) begin
        if (tx_done) done_cnt++;
        if (tx_error) begin
            err_cnt++;
            last_code = err_code;
            err_cyc   = cyc;
        end
    end

    initial begin
        repeat (60000) @(posedge clock);
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("vector %0d %s observed=0x%0h expected=0x%0h", vectors, tag, obs, exp);
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clock);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    // Counts the cycles with ps2_clk_oe high, starting at the current negedge.
    // Returns -1 if the clock is never released.
    task automatic wait_release(output int hi, output int rel);
        bit seen = 1'b0;
        hi  = 0;
        rel = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            if (ps2_clk_oe) begin
                hi++;
                @(negedge clock);
            end else begin
                rel  = cyc;
                seen = 1'b1;
            end
        end
        if (!seen) hi = -1;
    endtask

    // Device model: 100-cycle clock period, sampling on rising edges.
    // mode 0 = acknowledge, 1 = no acknowledge, 2 = acknowledge plus a
    // stray tx_start at fall 3, 3 = reset asserted at fall 5.
    task automatic dev_frame(input int mode, output logic [10:0] bits);
        bit aborted = 1'b0;
        bits    = '0;
        bits[0] = ps2_data_in;
        repeat (40) @(negedge clock);
        for (int i = 1; i <= 10 && !aborted; i++) begin
            @(negedge clock);
            dev_clk_low = 1'b1;
            if (mode == 3 && i == 5) begin
                reset = 1'b1;
                @(negedge clock);
                check("t6_reset_clk_oe", ps2_clk_oe, 1'b0);
                check("t6_reset_data_oe", ps2_data_oe, 1'b0);
                check("t6_reset_ready", tx_ready, 1'b1);
                check("t6_reset_busy", tx_busy, 1'b0);
                check("t6_reset_no_done", tx_done, 1'b0);
                check("t6_reset_no_error", tx_error, 1'b0);
                dev_clk_low = 1'b0;
                reset       = 1'b0;
                aborted     = 1'b1;
            end else begin
                if (mode == 2 && i == 3) begin
                    tx_data  = 8'h55;
                    tx_start = 1'b1;
                    @(negedge clock);
                    tx_start = 1'b0;
                    check("t5_stray_start_ready", tx_ready, 1'b0);
                    repeat (49) @(negedge clock);
                end else begin
                    repeat (50) @(negedge clock);
                end
                dev_clk_low = 1'b0;
                bits[i]     = ps2_data_in;
                repeat (50) @(negedge clock);
            end
        end
        if (!aborted) begin
            if (mode != 1) dev_data_low = 1'b1;
            repeat (10) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (50) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clock);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int base, input string tag);
        for (int k = 0; k < 1000 && done_cnt == base; k++) @(negedge clock);
        check(tag, done_cnt, base + 1);
    endtask

    task automatic wait_err(input int base, input int bound, input string tag);
        for (int k = 0; k < bound && err_cnt == base; k++) @(negedge clock);
        check(tag, err_cnt, base + 1);
    endtask

    initial begin
        int          hi, rel, bd, be;
        logic [10:0] bits;

        // Reset state
        repeat (4) @(negedge clock);
        check("reset_ready", tx_ready, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        check("reset_error", tx_error, 1'b0);
        check("reset_err_code", err_code, 2'b00);
        check("reset_clk_oe", ps2_clk_oe, 1'b0);
        check("reset_data_oe", ps2_data_oe, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // 1: 0xED with acknowledge
        bd = done_cnt; be = err_cnt;
        start_tx(8'hED);
        check("t1_cycle1_clk_oe", ps2_clk_oe, 1'b1);
        check("t1_cycle1_ready", tx_ready, 1'b0);
        check("t1_cycle1_busy", tx_busy, 1'b1);
        check("t1_cycle1_data_oe", ps2_data_oe, 1'b0);
        wait_release(hi, rel);
        check("t1_clk_oe_high_cycles", hi, 110);
        dev_frame(0, bits);
        check("t1_bits_ED", bits, 11'h7DA);
        wait_done(bd, "t1_done");
        repeat (20) @(negedge clock);
        check("t1_done_once", done_cnt, bd + 1);
        check("t1_no_error", err_cnt, be);
        check("t1_idle_ready", tx_ready, 1'b1);
        check("t1_idle_clk_oe", ps2_clk_oe, 1'b0);
        check("t1_idle_data_oe", ps2_data_oe, 1'b0);

        // 2: 0xF4 (parity 0), then 0x00 (parity 1)
        bd = done_cnt;
        start_tx(8'hF4);
        wait_release(hi, rel);
        dev_frame(0, bits);
        check("t2_bits_F4", bits, 11'h5E8);
        check("t2_parity_F4", bits[9], 1'b0);
        wait_done(bd, "t2_done_F4");
        repeat (20) @(negedge clock);
        bd = done_cnt;
        start_tx(8'h00);
        wait_release(hi, rel);
        dev_frame(0, bits);
        check("t2_bits_00", bits, 11'h600);
        check("t2_parity_00", bits[9], 1'b1);
        wait_done(bd, "t2_done_00");
        repeat (20) @(negedge clock);

        // 3: no acknowledge
        bd = done_cnt; be = err_cnt;
        start_tx(8'hED);
        wait_release(hi, rel);
        dev_frame(1, bits);
        wait_err(be, 1000, "t3_error_pulse");
        check("t3_err_code", last_code, 2'b10);
        repeat (20) @(negedge clock);
        check("t3_no_done", done_cnt, bd);
        check("t3_clk_oe", ps2_clk_oe, 1'b0);
        check("t3_data_oe", ps2_data_oe, 1'b0);
        check("t3_ready", tx_ready, 1'b1);

        // 4: device never clocks -> timeout 20000 cycles after release
        bd = done_cnt; be = err_cnt;
        start_tx(8'hED);
        wait_release(hi, rel);
        wait_err(be, 25000, "t4_error_pulse");
        check("t4_err_delay", err_cyc - rel, 20000);
        check("t4_err_code", last_code, 2'b01);
        check("t4_no_done", done_cnt, bd);
        check("t4_clk_oe", ps2_clk_oe, 1'b0);
        check("t4_data_oe", ps2_data_oe, 1'b0);
        repeat (20) @(negedge clock);
        check("t4_err_code_held", err_code, 2'b01);

        // 5: stray tx_start (0x55) during SEND is ignored
        bd = done_cnt;
        start_tx(8'h3C);
        check("t5_err_code_cleared", err_code, 2'b00);
        wait_release(hi, rel);
        dev_frame(2, bits);
        check("t5_bits_3C", bits, 11'h678);
        wait_done(bd, "t5_done");
        repeat (200) @(negedge clock);
        check("t5_not_queued", tx_ready, 1'b1);
        check("t5_done_count", done_cnt, bd + 1);

        // 6: reset at fall 5, then 0xFF completes
        bd = done_cnt; be = err_cnt;
        start_tx(8'h00);
        wait_release(hi, rel);
        dev_frame(3, bits);
        repeat (200) @(negedge clock);
        check("t6_no_done_after_reset", done_cnt, bd);
        check("t6_no_error_after_reset", err_cnt, be);
        start_tx(8'hFF);
        wait_release(hi, rel);
        check("t6_clk_oe_high_cycles", hi, 110);
        dev_frame(0, bits);
        check("t6_bits_FF", bits, 11'h7FE);
        wait_done(bd, "t6_done_FF");

        repeat (20) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
